// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants, prefix-FSM state type and helpers for the PS/2 scancode receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam int         PS2_PAUSE_LEN = 7;

    // Keyboard status/protocol bytes that never describe a key.
    localparam logic [7:0] PS2_CODE_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_CODE_ACK      = 8'hFA;
    localparam logic [7:0] PS2_CODE_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CODE_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_CODE_OVERRUN0 = 8'h00;
    localparam logic [7:0] PS2_CODE_OVERRUN1 = 8'hFF;

    typedef enum logic [2:0] {
        PFX_IDLE,
        PFX_EXT,
        PFX_BRK,
        PFX_EXT_BRK,
        PFX_PAUSE
    } pfxState_t;

    function automatic logic isNonKey(input logic [7:0] b);
        return (b == PS2_CODE_BAT_OK)   || (b == PS2_CODE_ACK)      ||
               (b == PS2_CODE_ECHO)     || (b == PS2_CODE_RESEND)   ||
               (b == PS2_CODE_OVERRUN0) || (b == PS2_CODE_OVERRUN1);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Key-event bus between the scancode receiver and the per-key decoders.
interface ps2_scancode_rx_if;
    logic [8:0] keyCode;
    logic       make;
    logic       brakee;
    logic       frame_error;

    modport master (output keyCode, make, brakee, frame_error);
    modport slave  (input  keyCode, make, brakee, frame_error);
endinterface

// File: rtl/ps2_scancode_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronizers, falling-edge detect,
// 11-bit shift, odd-parity/stop validation and mid-frame timeout.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rxByte,
    output logic       byteValid,
    output logic       frameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clkSync;
    logic [SYNC_STAGES-1:0] dataSync;
    logic                   prevClk;
    logic                   fallEdge;
    logic                   dataBit;
    logic [3:0]             bitCnt;
    logic [8:0]             shiftReg;
    logic [TW-1:0]          timeoutCnt;

    assign fallEdge = prevClk & ~clkSync[SYNC_STAGES-1];
    assign dataBit  = dataSync[SYNC_STAGES-1];

    // Bring both pins into the clk domain; idle-high reset avoids a false edge.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            clkSync  <= '1;
            dataSync <= '1;
            prevClk  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[SYNC_STAGES-2:0], ps2_clk};
            dataSync <= {dataSync[SYNC_STAGES-2:0], ps2_data};
            prevClk  <= clkSync[SYNC_STAGES-1];
        end
    end

    // Shift in one bit per falling edge, validate at the stop bit, abort stalled frames.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            bitCnt     <= '0;
            shiftReg   <= '0;
            timeoutCnt <= '0;
            rxByte     <= '0;
            byteValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            byteValid  <= 1'b0;
            frameError <= 1'b0;
            if (fallEdge) begin
                timeoutCnt <= '0;
                if (bitCnt == 4'd0) begin
                    if (!dataBit) begin
                        bitCnt <= 4'd1;
                    end
                end else if (bitCnt == 4'd10) begin
                    bitCnt <= 4'd0;
                    if (dataBit && (^shiftReg)) begin
                        rxByte    <= shiftReg[7:0];
                        byteValid <= 1'b1;
                    end else begin
                        frameError <= 1'b1;
                    end
                end else begin
                    shiftReg <= {dataBit, shiftReg[8:1]};
                    bitCnt   <= bitCnt + 4'd1;
                end
            end else if (bitCnt != 4'd0) begin
                if (timeoutCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeoutCnt <= '0;
                    bitCnt     <= 4'd0;
                    frameError <= 1'b1;
                end else begin
                    timeoutCnt <= timeoutCnt + 1'b1;
                end
            end else begin
                timeoutCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard front end: turns raw set-2 frames into make/brakee key events.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    ps2_scancode_rx_if.master         keyBus
);

    logic [7:0] rxByte;
    logic       rxByteValid;
    logic       rxFrameError;

    pfxState_t  state;
    logic [2:0] skipCnt;
    logic [8:0] keyCodeR;
    logic       makeR;
    logic       brakeeR;
    logic       frameErrR;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) frameRx (
        .clk        (clk),
        .resetN     (resetN),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rxByte     (rxByte),
        .byteValid  (rxByteValid),
        .frameError (rxFrameError)
    );

    assign keyBus.keyCode     = keyCodeR;
    assign keyBus.make        = makeR;
    assign keyBus.brakee      = brakeeR;
    assign keyBus.frame_error = frameErrR;

    // Prefix FSM: strips E0/F0/E1 prefixes and emits at most one key event per byte.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state     <= PFX_IDLE;
            skipCnt   <= '0;
            keyCodeR  <= '0;
            makeR     <= 1'b0;
            brakeeR   <= 1'b0;
            frameErrR <= 1'b0;
        end else begin
            makeR     <= 1'b0;
            brakeeR   <= 1'b0;
            frameErrR <= rxFrameError;
            if (rxFrameError) begin
                state <= PFX_IDLE;
            end else if (rxByteValid) begin
                case (state)
                    PFX_IDLE: begin
                        if (rxByte == PS2_PFX_EXT) begin
                            state <= PFX_EXT;
                        end else if (rxByte == PS2_PFX_BRK) begin
                            state <= PFX_BRK;
                        end else if (rxByte == PS2_PFX_PAUSE) begin
                            state   <= PFX_PAUSE;
                            skipCnt <= 3'(PS2_PAUSE_LEN);
                        end else if (!isNonKey(rxByte)) begin
                            keyCodeR <= {1'b0, rxByte};
                            makeR    <= 1'b1;
                        end
                    end
                    PFX_EXT: begin
                        if (rxByte == PS2_PFX_BRK) begin
                            state <= PFX_EXT_BRK;
                        end else if (rxByte != PS2_PFX_EXT) begin
                            keyCodeR <= {1'b1, rxByte};
                            makeR    <= 1'b1;
                            state    <= PFX_IDLE;
                        end
                    end
                    PFX_BRK: begin
                        if (rxByte == PS2_PFX_EXT) begin
                            state <= PFX_EXT;
                        end else if (rxByte != PS2_PFX_BRK) begin
                            keyCodeR <= {1'b0, rxByte};
                            brakeeR  <= 1'b1;
                            state    <= PFX_IDLE;
                        end
                    end
                    PFX_EXT_BRK: begin
                        if ((rxByte != PS2_PFX_EXT) && (rxByte != PS2_PFX_BRK)) begin
                            keyCodeR <= {1'b1, rxByte};
                            brakeeR  <= 1'b1;
                            state    <= PFX_IDLE;
                        end
                    end
                    PFX_PAUSE: begin
                        skipCnt <= skipCnt - 3'd1;
                        if (skipCnt <= 3'd1) begin
                            state <= PFX_IDLE;
                        end
                    end
                    default: state <= PFX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: table of frames plus corner-case sequences,
// with a scoreboard queue of expected key events.
module tb_ps2_scancode_rx;

    localparam int TIMEOUT = 300;
    localparam int SYNC    = 2;
    localparam int HALF    = 10;

    localparam int K_NONE = 0;
    localparam int K_MAKE = 1;
    localparam int K_BRK  = 2;
    localparam int K_ERR  = 3;

    localparam int BAD_NONE   = 0;
    localparam int BAD_PARITY = 1;
    localparam int BAD_STOP   = 2;

    typedef struct {
        logic [7:0] data;
        int         bad;
        int         kind;
        logic [8:0] code;
        logic [8:0] hold;
    } vec_t;

    typedef struct {
        int         kind;
        logic [8:0] code;
    } ev_t;

    logic clk;
    logic resetN;
    logic ps2Clk;
    logic ps2Data;

    int   checks;
    int   errors;
    int   cycle;
    int   stopCycle;
    int   lastEventCycle;
    ev_t  expQ[$];
    vec_t vecs[$];

    ps2_scancode_rx_if keyBus ();

    ps2_scancode_rx #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .ps2_clk  (ps2Clk),
        .ps2_data (ps2Data),
        .keyBus   (keyBus.master)
    );

    // Free-running system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency measurement.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expectEvent(input int kind, input logic [8:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        expQ.push_back(e);
    endtask

    // Drive one PS/2 frame (or the first nEdges bits of it) from the device side.
    task automatic applyStimulus(input logic [7:0] data, input int bad, input int nEdges);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        bits[9]   = (bad == BAD_PARITY) ? (^data) : ~(^data);
        bits[10]  = (bad == BAD_STOP) ? 1'b0 : 1'b1;
        for (int i = 0; i < nEdges; i++) begin
            @(posedge clk); #2;
            ps2Data = bits[i];
            repeat (HALF) @(posedge clk);
            #2;
            ps2Clk = 1'b0;
            if (i == 10) stopCycle = cycle;
            repeat (HALF) @(posedge clk);
            #2;
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    // Monitor: every output pulse is matched against the scoreboard head.
    initial begin
        int  kind;
        ev_t e;
        forever begin
            @(posedge clk); #1;
            if (!resetN && (keyBus.make || keyBus.brakee || keyBus.frame_error)) begin
                checkOutput("makeBrakeExclusive", {8'b0, keyBus.make & keyBus.brakee}, 9'h0);
                kind = keyBus.make ? K_MAKE : (keyBus.brakee ? K_BRK : K_ERR);
                lastEventCycle = cycle;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedEvent", 9'(kind), 9'(K_NONE));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("eventKind", 9'(kind), 9'(e.kind));
                    if (kind != K_ERR) checkOutput("eventCode", keyBus.keyCode, e.code);
                end
            end
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        cycle          = 0;
        stopCycle      = 0;
        lastEventCycle = 0;
        ps2Clk         = 1'b1;
        ps2Data        = 1'b1;
        resetN         = 1'b1;

        vecs.push_back('{8'h1C, BAD_NONE,   K_MAKE, 9'h01C, 9'h01C});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h1C, BAD_NONE,   K_BRK,  9'h01C, 9'h01C});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h75, BAD_NONE,   K_MAKE, 9'h175, 9'h175});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h175});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h175});
        vecs.push_back('{8'h75, BAD_NONE,   K_BRK,  9'h175, 9'h175});
        vecs.push_back('{8'h29, BAD_PARITY, K_ERR,  9'h000, 9'h175});
        vecs.push_back('{8'h29, BAD_NONE,   K_MAKE, 9'h029, 9'h029});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h029});
        vecs.push_back('{8'h12, BAD_NONE,   K_MAKE, 9'h112, 9'h112});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h112});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h112});
        vecs.push_back('{8'h12, BAD_NONE,   K_BRK,  9'h112, 9'h112});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h112});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h112});
        vecs.push_back('{8'h75, BAD_NONE,   K_MAKE, 9'h175, 9'h175});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h175});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h175});
        vecs.push_back('{8'h6B, BAD_NONE,   K_MAKE, 9'h16B, 9'h16B});
        vecs.push_back('{8'hAA, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'hFA, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'hEE, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'hFE, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'h00, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'hFF, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h16B});
        vecs.push_back('{8'h1C, BAD_STOP,   K_ERR,  9'h000, 9'h16B});
        vecs.push_back('{8'h1C, BAD_NONE,   K_MAKE, 9'h01C, 9'h01C});
        vecs.push_back('{8'hE1, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h14, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h77, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'hE1, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h14, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h77, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'hAA, BAD_NONE,   K_NONE, 9'h000, 9'h01C});
        vecs.push_back('{8'h5A, BAD_NONE,   K_MAKE, 9'h05A, 9'h05A});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h05A});
        vecs.push_back('{8'hF0, BAD_NONE,   K_NONE, 9'h000, 9'h05A});
        vecs.push_back('{8'hE0, BAD_NONE,   K_NONE, 9'h000, 9'h05A});
        vecs.push_back('{8'h1F, BAD_NONE,   K_BRK,  9'h11F, 9'h11F});

        // Power-on reset state.
        repeat (4) @(posedge clk);
        #1;
        checkOutput("resetKeyCode", keyBus.keyCode, 9'h000);
        checkOutput("resetMake", {8'b0, keyBus.make}, 9'h0);
        checkOutput("resetBrakee", {8'b0, keyBus.brakee}, 9'h0);
        checkOutput("resetFrameError", {8'b0, keyBus.frame_error}, 9'h0);
        #1;
        resetN = 1'b0;
        repeat (4) @(posedge clk);

        // Latency from stop-bit falling edge to make pulse.
        expectEvent(K_MAKE, 9'h01C);
        applyStimulus(8'h1C, BAD_NONE, 11);
        checkOutput("makeLatency", 9'(lastEventCycle - stopCycle), 9'(SYNC + 2));
        checkOutput("holdAfterFirst", keyBus.keyCode, 9'h01C);

        // Table of frames with expected events and held keyCode.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kind != K_NONE) expectEvent(vecs[i].kind, vecs[i].code);
            applyStimulus(vecs[i].data, vecs[i].bad, 11);
            checkOutput($sformatf("holdVec%0d", i), keyBus.keyCode, vecs[i].hold);
        end

        // Break prefix, then a stalled partial frame, then a good byte.
        applyStimulus(8'hF0, BAD_NONE, 11);
        expectEvent(K_ERR, 9'h000);
        applyStimulus(8'h55, BAD_NONE, 5);
        repeat (TIMEOUT + 50) @(posedge clk);
        expectEvent(K_MAKE, 9'h029);
        applyStimulus(8'h29, BAD_NONE, 11);
        checkOutput("holdAfterTimeout", keyBus.keyCode, 9'h029);

        // Lone falling edge with data high is ignored as a glitch.
        @(posedge clk); #2;
        ps2Data = 1'b1;
        repeat (HALF) @(posedge clk);
        #2 ps2Clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #2 ps2Clk = 1'b1;
        repeat (HALF) @(posedge clk);
        expectEvent(K_MAKE, 9'h033);
        applyStimulus(8'h33, BAD_NONE, 11);
        checkOutput("holdAfterGlitch", keyBus.keyCode, 9'h033);

        // Reset in the middle of a frame discards it.
        applyStimulus(8'h1C, BAD_NONE, 4);
        @(posedge clk); #2;
        resetN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midResetKeyCode", keyBus.keyCode, 9'h000);
        checkOutput("midResetMake", {8'b0, keyBus.make}, 9'h0);
        checkOutput("midResetBrakee", {8'b0, keyBus.brakee}, 9'h0);
        #1;
        resetN = 1'b0;
        repeat (4) @(posedge clk);
        expectEvent(K_MAKE, 9'h01C);
        applyStimulus(8'h1C, BAD_NONE, 11);
        checkOutput("holdAfterReset", keyBus.keyCode, 9'h01C);

        repeat (20) @(posedge clk);
        checkOutput("pendingEvents", 9'(expQ.size()), 9'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
